core_dispatcher: RTL

- Schedules the row jobs of a matrix multiplication across NUM_CORES processor cores.
- Latches a row count on begin_process, then hands out one row index per cycle to an idle core, chosen round-robin.
- Counts row completions and raises end_process when every row has finished. end_process feeds the main controller's process->alldone transition.
- Sits between the top-level main controller and the core array.

---
 rtl/core_sched_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/core_dispatcher.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/core_sched_pkg.sv
// Shared definitions for the row-job dispatcher: FSM encoding, default sizes
// and a popcount helper for counting simultaneous core completions.
package core_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DISPATCH = 2'b01,
        DRAIN    = 2'b10,
        DONE     = 2'b11
    } sched_state_t;

    localparam int DEFAULT_NUM_CORES = 4;
    localparam int DEFAULT_ROW_W     = 8;

    function automatic int unsigned popcount(input logic [31:0] vec);
        int unsigned count;
        count = 0;
        for (int i = 0; i < 32; i++) begin
            count = count + 32'(vec[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping around; the pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             valid
);

    logic [PTR_W:0]   cand;
    logic [PTR_W-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = '0;
        cand_idx  = '0;
        for (int off = 0; off < N; off++) begin
            cand = {1'b0, ptr} + (PTR_W + 1)'(off);
            if (cand >= (PTR_W + 1)'(N)) begin
                cand = cand - (PTR_W + 1)'(N);
            end
            cand_idx = cand[PTR_W-1:0];
            if (!valid && req[cand_idx]) begin
                valid           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/core_dispatcher.sv
// Hands out matrix-row jobs to idle cores one per cycle in round-robin order and
// raises end_process once every latched row has reported completion.
module core_dispatcher
    import core_sched_pkg::*;
#(
    parameter int NUM_CORES = DEFAULT_NUM_CORES,
    parameter int ROW_W     = DEFAULT_ROW_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       begin_process,
    input  logic [ROW_W-1:0]           num_rows,
    input  logic [NUM_CORES-1:0]       core_ready,
    input  logic [NUM_CORES-1:0]       core_done,
    output logic [NUM_CORES-1:0]       core_start,
    output logic [NUM_CORES*ROW_W-1:0] core_row,
    output logic                       end_process,
    output logic                       busy
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = ROW_W + 1;

    sched_state_t state, state_next;

    logic [CNT_W-1:0]     total, total_next;
    logic [CNT_W-1:0]     next_row, next_row_next;
    logic [CNT_W-1:0]     rows_done, rows_done_next;
    logic [NUM_CORES-1:0] inflight, inflight_next;
    logic [PTR_W-1:0]     rr_ptr, rr_ptr_next;
    logic [NUM_CORES-1:0] core_start_next;

    logic [NUM_CORES-1:0][ROW_W-1:0] row_slots;

    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic [NUM_CORES-1:0] done_hits;
    logic [CNT_W-1:0]     done_count;
    logic                 accept;
    logic                 do_grant;

    // A core that finishes this cycle still counts as inflight until the edge,
    // so it only becomes eligible again on the following cycle.
    assign eligible   = core_ready & ~inflight;
    assign done_hits  = (state != IDLE) ? (core_done & inflight) : '0;
    assign done_count = CNT_W'(popcount(32'(done_hits)));
    assign accept     = begin_process && ((state == IDLE) || (state == DONE));
    assign do_grant   = (state == DISPATCH) && grant_valid && (next_row < total);

    rr_arbiter #(
        .N     (NUM_CORES),
        .PTR_W (PTR_W)
    ) u_arbiter (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (grant_valid)
    );

    always_comb begin
        state_next      = state;
        total_next      = total;
        next_row_next   = next_row;
        rows_done_next  = rows_done + done_count;
        inflight_next   = inflight & ~done_hits;
        rr_ptr_next     = rr_ptr;
        core_start_next = '0;

        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    total_next     = {1'b0, num_rows};
                    next_row_next  = '0;
                    rows_done_next = '0;
                    state_next     = (num_rows == '0) ? DONE : DISPATCH;
                end
            end
            DISPATCH: begin
                if (do_grant) begin
                    core_start_next = grant;
                    inflight_next   = inflight_next | grant;
                    next_row_next   = next_row + CNT_W'(1);
                    rr_ptr_next     = (grant_idx == PTR_W'(NUM_CORES - 1)) ?
                                      '0 : grant_idx + PTR_W'(1);
                end
                if (next_row_next >= total) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (rows_done_next == total) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status outputs follow the state with one register stage, so end_process
    // and busy change together on the edge after the FSM enters or leaves DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            total       <= '0;
            next_row    <= '0;
            rows_done   <= '0;
            inflight    <= '0;
            rr_ptr      <= '0;
            row_slots   <= '0;
            core_start  <= '0;
            end_process <= 1'b0;
            busy        <= 1'b0;
        end else begin
            total       <= total_next;
            next_row    <= next_row_next;
            rows_done   <= rows_done_next;
            inflight    <= inflight_next;
            rr_ptr      <= rr_ptr_next;
            core_start  <= core_start_next;
            end_process <= (state == DONE);
            busy        <= (state == DISPATCH) || (state == DRAIN);
            if (do_grant) begin
                row_slots[grant_idx] <= next_row[ROW_W-1:0];
            end
        end
    end

    assign core_row = row_slots;

endmodule
